lc3b_mem_ctrl: RTL and testbench

Multi-cycle main-memory unit for the LC-3b datapath, driven by the microsequencer's MIO.EN, R.W and DATA.SIZE controls. It holds the word-organised memory array, performs byte and word accesses, and returns the LC-3b ready signal R after a fixed access latency. Its rdata output feeds the MDR-load 2:1 16-bit mux, where MIO.EN selects memory data over the bus. Its wdata input comes from MDR.

---
 rtl/lc3b_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_lc3b_mem_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl - multi-cycle main memory for the LC-3b datapath.
//
// A request is accepted from IDLE when mio_en is high. The address, direction,
// size and write data are latched. The access commits on the edge that enters
// DONE. R (ready) is high for the single DONE cycle, LATENCY cycles after the
// request cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   mio_en     memory request (MIO.EN)
//   r_w        0 = read, 1 = write
//   data_size  0 = byte, 1 = word
//   addr       byte address from MAR
//   wdata      write data from MDR; byte writes use wdata[7:0]
//   rdata      registered read word (full word, even for byte reads)
//   ready      LC-3b R, one-cycle pulse
//   unaligned  one-cycle pulse with ready for a word access at an odd address
//   busy       high while the FSM is outside IDLE
module lc3b_mem_ctrl #(
    parameter int LATENCY   = 5,
    parameter int MEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        data_size,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        unaligned,
    output logic        busy
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       lat_addr;
    logic [15:0]       lat_wdata;
    logic              lat_rw;
    logic              lat_size;
    logic [15:0]       mem [MEM_WORDS];

    logic              accept;
    logic              commit;
    logic [15:0]       acc_addr;
    logic [15:0]       acc_wdata;
    logic              acc_rw;
    logic              acc_size;
    logic              acc_unaligned;
    logic [IDX_W-1:0]  acc_idx;

    // With LATENCY=1 the access commits on the accepting edge itself, so
    // the live inputs are used. Otherwise the latched copies are used.
    always_comb begin
        accept    = (state == IDLE) && mio_en;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_rw    = lat_rw;
        acc_size  = lat_size;
        if (state == IDLE) begin
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_rw    = r_w;
            acc_size  = data_size;
        end
        if (LATENCY == 1)
            commit = accept;
        else
            commit = (state == BUSY) && (cnt == CNT_W'(1));
        acc_unaligned = acc_size && acc_addr[0];
        // Upper address bits alias onto the array.
        acc_idx       = acc_addr[IDX_W:1];
    end

    // Request latch: data only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_rw    <= r_w;
            lat_size  <= data_size;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            unaligned <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 16'h0000;
        end else begin
            ready     <= 1'b0;
            unaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (mio_en) begin
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        state <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
            if (commit) begin
                ready     <= 1'b1;
                unaligned <= acc_unaligned;
                // Byte reads return the full word; lane select is downstream.
                if (!acc_rw && !acc_unaligned)
                    rdata <= mem[acc_idx];
            end
        end
    end

    // Array write. A reset on the commit edge discards the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc_rw && !acc_unaligned) begin
            if (acc_size)
                mem[acc_idx] <= acc_wdata;
            else if (acc_addr[0])
                mem[acc_idx][15:8] <= acc_wdata[7:0];
            else
                mem[acc_idx][7:0] <= acc_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Directed testbench for lc3b_mem_ctrl: a default instance (LATENCY=5,
// MEM_WORDS=32768) and a small one (LATENCY=1, MEM_WORDS=1024) share the
// stimulus; sel steers mio_en and the observed outputs.
module tb_lc3b_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mio_en;
    logic        r_w;
    logic        data_size;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        sel;

    logic [15:0] rdata0, rdata1;
    logic        ready0, ready1, unal0, unal1, busy0, busy1;
    logic        mio_en0, mio_en1;
    logic [15:0] rdata_m;
    logic        ready_m, unal_m, busy_m;

    int n_checks = 0;
    int n_fail   = 0;

    assign mio_en0 = mio_en & ~sel;
    assign mio_en1 = mio_en & sel;
    assign rdata_m = sel ? rdata1 : rdata0;
    assign ready_m = sel ? ready1 : ready0;
    assign unal_m  = sel ? unal1  : unal0;
    assign busy_m  = sel ? busy1  : busy0;

    lc3b_mem_ctrl dut (
        .clk(clk), .reset(reset), .mio_en(mio_en0), .r_w(r_w),
        .data_size(data_size), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .unaligned(unal0), .busy(busy0)
    );

    lc3b_mem_ctrl #(.LATENCY(1), .MEM_WORDS(1024)) dut1 (
        .clk(clk), .reset(reset), .mio_en(mio_en1), .r_w(r_w),
        .data_size(data_size), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .unaligned(unal1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // One request; returns the cycle number of ready (-1 if none within
    // budget), plus rdata/unaligned in that cycle. Inputs are scrambled
    // after the request cycle to show the latched copy is used.
    task automatic req(input logic rw, input logic sz, input logic [15:0] a,
                       input logic [15:0] wd, output logic [15:0] rd,
                       output logic un, output int lat);
        @(posedge clk); #1;
        mio_en = 1'b1; r_w = rw; data_size = sz; addr = a; wdata = wd;
        lat = -1; rd = 16'h0; un = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                mio_en = 1'b0; r_w = ~rw; data_size = ~sz;
                addr = ~a; wdata = ~wd;
            end
            if (ready_m) begin
                lat = k; rd = rdata_m; un = unal_m;
                break;
            end
        end
        @(posedge clk); #1;
        chk("ready_one_cycle", {15'd0, ready_m}, 16'd0);
    endtask

    logic [15:0] rd;
    logic        un;
    int          lat;
    int          nrdy;
    logic [15:0] rv;

    initial begin
        reset = 1'b1; mio_en = 1'b0; r_w = 1'b0; data_size = 1'b0;
        addr = 16'h0; wdata = 16'h0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_rdata", rdata0, 16'h0000);
        chk("rst_ready", {15'd0, ready0}, 16'd0);
        chk("rst_unal",  {15'd0, unal0}, 16'd0);
        chk("rst_busy",  {15'd0, busy0}, 16'd0);

        // Word write then word read
        req(1'b1, 1'b1, 16'h3000, 16'hBEEF, rd, un, lat);
        chk("t1_wr_lat", 16'(lat), 16'd5);
        chk("t1_wr_unal", {15'd0, un}, 16'd0);
        req(1'b0, 1'b1, 16'h3000, 16'h0000, rd, un, lat);
        chk("t1_rd_lat", 16'(lat), 16'd5);
        chk("t1_rd_data", rd, 16'hBEEF);
        chk("t1_rd_unal", {15'd0, un}, 16'd0);

        // Byte writes into each lane
        req(1'b1, 1'b0, 16'h3001, 16'h0012, rd, un, lat);
        chk("t2_bw_hi_unal", {15'd0, un}, 16'd0);
        req(1'b0, 1'b1, 16'h3000, 16'h0000, rd, un, lat);
        chk("t2_rd_hi", rd, 16'h12EF);
        req(1'b1, 1'b0, 16'h3000, 16'h0034, rd, un, lat);
        req(1'b0, 1'b1, 16'h3000, 16'h0000, rd, un, lat);
        chk("t2_rd_lo", rd, 16'h1234);

        // Unaligned word accesses
        req(1'b0, 1'b1, 16'h3001, 16'h0000, rd, un, lat);
        chk("t3_ur_lat", 16'(lat), 16'd5);
        chk("t3_ur_unal", {15'd0, un}, 16'd1);
        chk("t3_ur_rdata", rd, 16'h1234);
        req(1'b1, 1'b1, 16'h3001, 16'hFFFF, rd, un, lat);
        chk("t3_uw_unal", {15'd0, un}, 16'd1);
        req(1'b0, 1'b1, 16'h3000, 16'h0000, rd, un, lat);
        chk("t3_rd_after", rd, 16'h1234);

        // Reset in the middle of a write
        req(1'b1, 1'b1, 16'h4000, 16'hAAAA, rd, un, lat);
        req(1'b0, 1'b1, 16'h4000, 16'h0000, rd, un, lat);
        chk("t4_pre_rd", rd, 16'hAAAA);
        @(posedge clk); #1;
        mio_en = 1'b1; r_w = 1'b1; data_size = 1'b1; addr = 16'h4000; wdata = 16'h5555;
        nrdy = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) mio_en = 1'b0;
            if (ready_m) nrdy++;
            if (k == 2) chk("t4_busy_mid", {15'd0, busy_m}, 16'd1);
            if (k == 3) reset = 1'b1;
            if (k == 4) begin
                reset = 1'b0;
                chk("t4_busy", {15'd0, busy_m}, 16'd0);
                chk("t4_rdata", rdata_m, 16'h0000);
                chk("t4_unal", {15'd0, unal_m}, 16'd0);
            end
        end
        chk("t4_no_ready", 16'(nrdy), 16'd0);
        req(1'b0, 1'b1, 16'h4000, 16'h0000, rd, un, lat);
        chk("t4_rd_kept", rd, 16'hAAAA);

        // Back-to-back reads with addr moving during BUSY
        @(posedge clk); #1;
        mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; addr = 16'h3000;
        rv = 16'h0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            if (ready_m) rv[k] = 1'b1;
            if (k == 5)  chk("t5_rd1", rdata_m, 16'h1234);
            if (k == 11) chk("t5_rd2", rdata_m, 16'hAAAA);
            if (k == 2)  addr = 16'h4000;
            if (k == 8)  addr = 16'h3000;
            if (k == 11) mio_en = 1'b0;
        end
        chk("t5_ready_cycles", rv, 16'h0820);

        // LATENCY=1, MEM_WORDS=1024 instance: aliasing
        sel = 1'b1;
        req(1'b1, 1'b1, 16'hFFFE, 16'h7777, rd, un, lat);
        chk("t6_wr_lat", 16'(lat), 16'd1);
        req(1'b0, 1'b1, 16'h07FE, 16'h0000, rd, un, lat);
        chk("t6_rd_lat", 16'(lat), 16'd1);
        chk("t6_rd_alias", rd, 16'h7777);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
